// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router packet controller.
package router_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 30;
  localparam logic [1:0]  ADDR_INVALID    = 2'd3;

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR,
    WAIT_TILL_EMPTY
  } state_e;

  // One-hot port select for a 2-bit destination; the invalid address selects nothing.
  function automatic logic [2:0] addr_onehot(input logic [1:0] addr);
    logic [2:0] oh;
    oh = '0;
    case (addr)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/router_timeout.sv
// Per-port read-timeout: counts consecutive cycles of valid-but-unread data
// and emits a registered one-cycle soft reset when the limit is reached.
module router_timeout
  import router_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic vld_i,
  input  logic read_enb_i,
  input  logic fifo_empty_i,
  output logic soft_reset_o
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sr_q,  sr_d;

  // Next-state: clear on read or empty, count idle valid cycles, fire on the last one.
  always_comb begin
    cnt_d = cnt_q;
    sr_d  = 1'b0;
    if (read_enb_i || fifo_empty_i) begin
      cnt_d = '0;
    end else if (vld_i) begin
      if (cnt_q == CW'(TIMEOUT - 1)) begin
        cnt_d = '0;
        sr_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Counter and pulse registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      sr_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

  assign soft_reset_o = sr_q;

endmodule

// File: rtl/router_ctrl.sv
// Packet-level controller for the 1x3 router: header decode, source stall,
// one-hot FIFO write steering and per-port read-timeout soft resets.
module router_ctrl
  import router_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] read_enb,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       busy,
  output logic [2:0] write_enb,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       lp_state,
  output logic       chk_state,
  output logic [2:0] vld_out,
  output logic [2:0] soft_reset
);

  state_e     state_q, state_d;
  logic [1:0] addr_q,  addr_d;
  logic       wr;

  // Padded to 4 entries so the latched address (which may be the invalid 3) indexes safely.
  logic [3:0] full4, empty4, sr4, empty_in4;
  logic       unused_len;

  assign full4      = {1'b0, fifo_full};
  assign empty4     = {1'b0, fifo_empty};
  assign sr4        = {1'b0, soft_reset};
  assign empty_in4  = {1'b0, fifo_empty};
  assign unused_len = ^data_in[7:2];

  assign vld_out = ~fifo_empty;

  for (genvar g = 0; g < 3; g++) begin : g_timeout
    router_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clock        (clock),
      .reset        (reset),
      .vld_i        (vld_out[g]),
      .read_enb_i   (read_enb[g]),
      .fifo_empty_i (fifo_empty[g]),
      .soft_reset_o (soft_reset[g])
    );
  end

  // State and latched destination address.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state, address latch and Moore outputs decoded from the registered state.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr         = 1'b0;
    busy       = 1'b0;
    detect_add = 1'b0;
    lfd_state  = 1'b0;
    ld_state   = 1'b0;
    laf_state  = 1'b0;
    full_state = 1'b0;
    lp_state   = 1'b0;
    chk_state  = 1'b0;

    case (state_q)
      DECODE_ADDRESS: begin
        detect_add = 1'b1;
        if (pkt_valid) begin
          addr_d = data_in[1:0];
          if (data_in[1:0] != ADDR_INVALID) begin
            if (empty_in4[data_in[1:0]]) state_d = LOAD_FIRST_DATA;
            else                         state_d = WAIT_TILL_EMPTY;
          end
        end
      end
      LOAD_FIRST_DATA: begin
        lfd_state = 1'b1;
        busy      = 1'b1;
        wr        = 1'b1;
        state_d   = LOAD_DATA;
      end
      LOAD_DATA: begin
        ld_state = 1'b1;
        wr       = 1'b1;
        if (full4[addr_q])   state_d = FIFO_FULL_STATE;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        full_state = 1'b1;
        busy       = 1'b1;
        if (!full4[addr_q]) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        laf_state = 1'b1;
        busy      = 1'b1;
        wr        = 1'b1;
        if (parity_done)        state_d = DECODE_ADDRESS;
        else if (low_pkt_valid) state_d = LOAD_PARITY;
        else                    state_d = LOAD_DATA;
      end
      LOAD_PARITY: begin
        lp_state = 1'b1;
        busy     = 1'b1;
        wr       = 1'b1;
        state_d  = CHECK_PARITY_ERROR;
      end
      CHECK_PARITY_ERROR: begin
        chk_state = 1'b1;
        busy      = 1'b1;
        if (full4[addr_q]) state_d = FIFO_FULL_STATE;
        else               state_d = DECODE_ADDRESS;
      end
      WAIT_TILL_EMPTY: begin
        busy = 1'b1;
        if (empty4[addr_q]) state_d = LOAD_FIRST_DATA;
      end
      default: state_d = DECODE_ADDRESS;
    endcase

    // A soft reset of the port being written abandons the packet from any state.
    if (sr4[addr_q]) state_d = DECODE_ADDRESS;

    write_enb = wr ? addr_onehot(addr_q) : '0;
  end

endmodule

// File: tb/tb_router_ctrl.sv
// Scoreboard bench for router_ctrl: each packet scenario pushes the write
// cycles it must produce; a negedge monitor pops one entry per observed write.
module tb_router_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full, fifo_empty, read_enb;
  logic       parity_done, low_pkt_valid;
  logic       busy, detect_add, lfd_state, ld_state, laf_state, full_state, lp_state, chk_state;
  logic [2:0] write_enb, vld_out, soft_reset;

  router_ctrl #(.TIMEOUT(30)) dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .read_enb(read_enb),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .busy(busy), .write_enb(write_enb), .detect_add(detect_add),
    .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .lp_state(lp_state), .chk_state(chk_state),
    .vld_out(vld_out), .soft_reset(soft_reset)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] we;
    logic busy, lfd, ld, laf, lp;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] port_bit(input int a);
    return 3'(1 << a);
  endfunction

  task automatic push(input int a, input logic b, input logic lfd, input logic ld,
                      input logic laf, input logic lp);
    wr_t e;
    e.we = port_bit(a); e.busy = b; e.lfd = lfd; e.ld = ld; e.laf = laf; e.lp = lp;
    exp_q.push_back(e);
  endtask

  // Expected write cycles of a packet loaded without stalls:
  // header (held during the first load), one write per pkt_valid-high payload
  // cycle plus the cycle pkt_valid falls, then the parity load.
  task automatic push_clean(input int a, input int len);
    push(a, 1, 1, 0, 0, 0);
    for (int i = 0; i < len + 1; i++) push(a, 0, 0, 1, 0, 0);
    push(a, 1, 0, 0, 0, 1);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every cycle the DUT writes, it must match the next expected write.
  always @(negedge clock) begin : monitor
    wr_t e;
    if (!reset && write_enb !== 3'b000) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got write_enb=%b expected none at %0t", write_enb, $time);
      end else begin
        e = exp_q.pop_front();
        chk("write_enb", 32'(write_enb), 32'(e.we));
        chk("write_busy", 32'(busy), 32'(e.busy));
        chk("write_lfd", 32'(lfd_state), 32'(e.lfd));
        chk("write_ld", 32'(ld_state), 32'(e.ld));
        chk("write_laf", 32'(laf_state), 32'(e.laf));
        chk("write_lp", 32'(lp_state), 32'(e.lp));
      end
    end
  end

  // From the first-load cycle: payload, parity byte, then parity check and back to decode.
  task automatic finish_packet(input int len);
    step();
    for (int i = 0; i < len; i++) begin
      data_in = 8'($urandom);
      step();
    end
    pkt_valid = 1'b0;
    data_in   = 8'($urandom);
    step();
    step();
    chk("chk_state", 32'(chk_state), 1);
    chk("chk_busy", 32'(busy), 1);
    chk("chk_no_write", 32'(write_enb), 0);
    step();
    chk("back_to_decode", 32'(detect_add), 1);
    chk("decode_busy", 32'(busy), 0);
  endtask

  task automatic run_clean(input int a, input int len);
    push_clean(a, len);
    pkt_valid = 1'b1;
    data_in   = 8'((len << 2) | a);
    step();
    finish_packet(len);
  endtask

  task automatic run_wait(input int len, input int waitcyc);
    fifo_empty = 3'b011;
    push_clean(2, len);
    pkt_valid = 1'b1;
    data_in   = 8'((len << 2) | 2);
    step();
    for (int w = 0; w < waitcyc; w++) begin
      chk("wait_busy", 32'(busy), 1);
      chk("wait_no_write", 32'(write_enb), 0);
      chk("wait_not_decode", 32'(detect_add), 0);
      chk("wait_vld_out", 32'(vld_out), 32'h4);
      step();
    end
    fifo_empty = 3'b111;
    step();
    finish_packet(len);
  endtask

  // k load cycles (the last one sees full), stall, then drain via low_pkt_valid.
  task automatic run_full(input int a, input int k, input int hold);
    push(a, 1, 1, 0, 0, 0);
    for (int i = 0; i < k; i++) push(a, 0, 0, 1, 0, 0);
    push(a, 1, 0, 0, 1, 0);
    push(a, 1, 0, 0, 0, 1);
    pkt_valid = 1'b1;
    data_in   = 8'((10 << 2) | a);
    step();
    step();
    for (int i = 0; i < k - 1; i++) begin
      data_in = 8'($urandom);
      step();
    end
    data_in   = 8'($urandom);
    fifo_full = port_bit(a);
    step();
    for (int h = 0; h < hold; h++) begin
      chk("full_state", 32'(full_state), 1);
      chk("full_busy", 32'(busy), 1);
      chk("full_no_write", 32'(write_enb), 0);
      step();
    end
    fifo_full     = 3'b000;
    pkt_valid     = 1'b0;
    low_pkt_valid = 1'b1;
    step();
    step();
    low_pkt_valid = 1'b0;
    step();
    chk("full_chk_state", 32'(chk_state), 1);
    step();
    chk("full_back_to_decode", 32'(detect_add), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; pkt_valid = 1'b0; data_in = '0; fifo_full = '0;
    fifo_empty = 3'b010; read_enb = '0; parity_done = 1'b0; low_pkt_valid = 1'b0;
    #12;
    chk("rst_detect_add", 32'(detect_add), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_write_enb", 32'(write_enb), 0);
    chk("rst_soft_reset", 32'(soft_reset), 0);
    chk("rst_flags", 32'({lfd_state, ld_state, laf_state, full_state, lp_state, chk_state}), 0);
    chk("rst_vld_out", 32'(vld_out), 32'h5);
    fifo_empty = 3'b111;
    step();
    reset = 1'b0;
    step();

    // Header 0x39: 14-byte payload to port 1.
    run_clean(1, 14);

    for (int n = 0; n < 6; n++) run_clean(int'($urandom_range(0, 2)), int'($urandom_range(1, 20)));

    run_wait(int'($urandom_range(1, 8)), 4);

    run_full(1, 3, 2);
    run_full(int'($urandom_range(0, 2)), int'($urandom_range(1, 6)), int'($urandom_range(1, 4)));

    // Invalid address: stay in decode, never write.
    pkt_valid = 1'b1;
    data_in   = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("addr3_decode", 32'(detect_add), 1);
      chk("addr3_no_write", 32'(write_enb), 0);
    end
    pkt_valid = 1'b0;
    step();

    // Idle timeout on port 0: pulse after the 30th unread valid cycle, one cycle wide.
    fifo_empty = 3'b110;
    for (int e = 1; e <= 29; e++) begin
      step();
      chk("to_quiet", 32'(soft_reset), 0);
    end
    step();
    chk("to_pulse", 32'(soft_reset), 1);
    step();
    chk("to_pulse_end", 32'(soft_reset), 0);
    fifo_empty = 3'b111;
    step();

    // A read on cycle 29 restarts the count.
    fifo_empty = 3'b110;
    for (int e = 1; e <= 28; e++) step();
    read_enb = 3'b001;
    step();
    read_enb = 3'b000;
    chk("to_read_quiet", 32'(soft_reset), 0);
    for (int e = 0; e < 12; e++) begin
      step();
      chk("to_read_quiet", 32'(soft_reset), 0);
    end
    fifo_empty = 3'b111;
    step();

    // Timeout while loading port 0: 31 load writes, then abandoned to decode.
    push(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 31; i++) push(0, 0, 0, 1, 0, 0);
    pkt_valid = 1'b1;
    data_in   = 8'((40 << 2) | 0);
    step();
    step();
    fifo_empty = 3'b110;
    for (int e = 1; e <= 30; e++) begin
      data_in = 8'($urandom);
      step();
    end
    pkt_valid = 1'b0;
    chk("to_active_pulse", 32'(soft_reset), 1);
    chk("to_active_ld", 32'(ld_state), 1);
    step();
    chk("to_active_decode", 32'(detect_add), 1);
    chk("to_active_no_write", 32'(write_enb), 0);
    fifo_empty = 3'b111;
    step();

    // Reset in the middle of a load; port 1 counter was near its limit.
    fifo_empty = 3'b101;
    for (int e = 0; e < 20; e++) step();
    push(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) push(0, 0, 0, 1, 0, 0);
    pkt_valid = 1'b1;
    data_in   = 8'((12 << 2) | 0);
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      data_in = 8'($urandom);
      step();
    end
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_write_enb", 32'(write_enb), 0);
    chk("midrst_detect_add", 32'(detect_add), 1);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ld", 32'(ld_state), 0);
    chk("midrst_vld_out", 32'(vld_out), 32'h2);
    pkt_valid = 1'b0;
    step();
    reset = 1'b0;
    for (int e = 0; e < 12; e++) begin
      step();
      chk("midrst_counter_cleared", 32'(soft_reset), 0);
    end
    fifo_empty = 3'b111;

    run_clean(2, 3);

    step();
    step();
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
